alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 4: operand width in bits.
REQ-002 Parameter RW, default 8: result width in bits, fixed at 2*DW.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) operation of requester N accepted this cycle.
REQ-007 reqN_op  input  3  (N=0,1) opcode.
REQ-008 reqN_a, reqN_b  input  DW  (N=0,1) unsigned operands.
REQ-009 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-010 rspN_ready  input  1  (N=0,1) requester N takes the result.
REQ-011 rsp_data  output  RW  result, shared by both response channels.
REQ-012 rsp_err  output  1  error flag qualifying rsp_data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done_cnt  output  8  count of completed response handshakes.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, and leave IDLE only on an accepted request.
REQ-016 In IDLE with at least one reqN_valid, the block SHALL grant one requester, assert only its reqN_ready combinationally in that cycle, capture op/a/b, and move to EXEC.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valid, the requester not served last wins; the priority pointer SHALL move only on a response handshake.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP, and also for the non-granted requester.
REQ-019 In EXEC the captured operands SHALL be zero-extended to RW bits and the result registered; the FSM SHALL move to RESP unconditionally after one cycle.
REQ-020 Opcodes: 000 a+b; 001 a-b mod 2^RW; 010 a*b; 011 a/b truncating; 100 a&b; 101 a|b.
REQ-021 Opcode 011 with b=0 SHALL give rsp_data=0xFF and rsp_err=1.
REQ-022 Opcodes 110 and 111 SHALL give rsp_data=0x00 and rsp_err=1.
REQ-023 rsp_err SHALL be 0 for every other operation.
REQ-024 In RESP only the granted requester's rspN_valid SHALL be high; rsp_data and rsp_err SHALL stay stable until rspN_ready.
REQ-025 On the rspN_valid && rspN_ready cycle the FSM SHALL return to IDLE, done_cnt SHALL increment (wrapping 255->0), and the pointer SHALL favour the other requester.
REQ-026 At most one operation SHALL be outstanding; minimum accept-to-accept spacing is 3 cycles.
REQ-027 Operand changes on the reqN inputs after acceptance SHALL NOT affect the captured result.
REQ-028 A request still valid at the end of RESP SHALL be eligible for grant in the following IDLE cycle.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE and the following values: reqN_ready=0, rspN_valid=0, rsp_data=0, rsp_err=0, busy=0, done_cnt=0, pointer favouring requester 0.
REQ-030 Reset mid-operation SHALL discard the in-flight operation without producing a response.
REQ-031 The first grant SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-032 Opcode constants, the FSM state encoding and the error result values (0xFF, 0x00) SHALL reside in the shared package alu_pkg.
REQ-033 The arithmetic SHALL be a separate sub-module alu_core (registered, 1-cycle latency, with an error output); alu_arbiter SHALL contain only the FSM, arbitration, operand capture and counter.

Verification
REQ-034 Single request: req0 op=000 a=9 b=7 with rsp0_ready=1 -> ready in cycle 0, rsp0_valid in cycle 2, rsp_data=0x10, err=0, done_cnt=1.
REQ-035 Contention: req0 and req1 both valid continuously with ops 010 3*5 and 001 3-5 -> grants alternate 0,1,0,1; results 0x0F and 0xFE.
REQ-036 Divide and illegal opcodes: op=011 a=15 b=0 -> 0xFF err=1; op=011 15/4 -> 0x03 err=0; op=111 -> 0x00 err=1.
REQ-037 Backpressure: rsp1_ready held low for 5 cycles -> rsp1_valid and rsp_data stable, req0_ready=0 throughout, completion on the first rsp1_ready=1 cycle.
REQ-038 Reset in EXEC: assert rst -> all outputs return to reset values immediately, no rspN_valid ever appears, done_cnt=0.
REQ-039 Counter wrap: 256 back-to-back completions -> done_cnt reads 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and error result values
// Purpose: constants shared by alu_core and alu_arbiter.
// Ports: none (package).
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Result values reported alongside rsp_err
    localparam logic [7:0] DIV0_RESULT    = 8'hFF;
    localparam logic [7:0] ILLEGAL_RESULT = 8'h00;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between two requesters and the arbiter
// Purpose: bundles both request channels, both response channels and status.
// Modports: slave  - arbiter side (drives reqN_ready, rspN_valid, rsp_data, rsp_err, busy, done_cnt)
//           master - requester side (drives reqN_valid/op/a/b, rspN_ready)
interface alu_arbiter_if #(
    parameter int DW = 4,
    parameter int RW = 2 * DW
);
    logic          req0_valid;
    logic          req0_ready;
    logic [2:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [2:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          rsp0_valid;
    logic          rsp0_ready;
    logic          rsp1_valid;
    logic          rsp1_ready;
    logic [RW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [7:0]    done_cnt;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy, done_cnt
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy, done_cnt
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered ALU, one-cycle latency, with error flag
// Purpose: computes op(a, b) on zero-extended operands when en is high and
//          holds the result otherwise, so the response stays stable.
// Ports: clk, rst (async high); en load strobe; op/a/b operands;
//        result/err registered outputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = 4,
    parameter int RW = 2 * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] result,
    output logic          err
);

    logic [RW-1:0] result_q, result_d;
    logic          err_q, err_d;
    logic [RW-1:0] a_ext, b_ext;

    assign a_ext = {{(RW-DW){1'b0}}, a};
    assign b_ext = {{(RW-DW){1'b0}}, b};

    always_comb begin
        result_d = result_q;
        err_d    = err_q;
        if (en) begin
            err_d = 1'b0;
            case (op)
                OP_ADD: result_d = a_ext + b_ext;
                OP_SUB: result_d = a_ext - b_ext;
                OP_MUL: result_d = a_ext * b_ext;
                OP_DIV: begin
                    if (b_ext == '0) begin
                        result_d = RW'(DIV0_RESULT);
                        err_d    = 1'b1;
                    end else begin
                        result_d = a_ext / b_ext;
                    end
                end
                OP_AND: result_d = a_ext & b_ext;
                OP_OR:  result_d = a_ext | b_ext;
                default: begin
                    result_d = RW'(ILLEGAL_RESULT);
                    err_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for alu_core
// Purpose: grants one request at a time, captures its operands, runs alu_core
//          and returns the result on the granted requester's response channel.
// Ports: clk, rst (async high); bus (alu_arbiter_if.slave) carrying both
//        request/response channels plus busy and done_cnt.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW = 4,
    parameter int RW = 2 * DW
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;   // requester owning the in-flight op
    logic          ptr_q, ptr_d;       // requester favoured on contention
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [7:0]    done_cnt_q, done_cnt_d;

    logic          sel;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic          core_en;
    logic [RW-1:0] core_result;
    logic          core_err;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        done_cnt_d = done_cnt_q;
        sel        = ptr_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        core_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst gates ready so no handshake is signalled while held in reset
                if (!rst && (bus.req0_valid || bus.req1_valid)) begin
                    sel        = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
                    req0_ready = !sel;
                    req1_ready = sel;
                    grant_d    = sel;
                    op_d       = sel ? bus.req1_op : bus.req0_op;
                    a_d        = sel ? bus.req1_a  : bus.req0_a;
                    b_d        = sel ? bus.req1_b  : bus.req0_b;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                core_en = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = !grant_q;
                rsp1_valid = grant_q;
                if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = done_cnt_q + 8'd1;
                    ptr_d      = !grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            ptr_q      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    alu_core #(
        .DW (DW),
        .RW (RW)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (core_en),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .err    (core_err)
    );

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp_data   = core_result;
    assign bus.rsp_err    = core_err;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_done = 0;

    alu_arbiter_if #(.DW(4), .RW(8)) bus ();

    alu_arbiter #(.DW(4), .RW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    // Single request from requester r, called at an IDLE negedge. Operands are
    // corrupted right after acceptance to show the captured copy is used.
    task automatic do_op(input logic r, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] ed, input logic ee,
                         input string tag);
        if (r) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        chk({tag, " grant"}, 32'(r ? bus.req1_ready : bus.req0_ready), 32'd1);
        chk({tag, " other_ready"}, 32'(r ? bus.req0_ready : bus.req1_ready), 32'd0);
        tick;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = a ^ 4'hF; bus.req0_b = b ^ 4'hF; bus.req0_op = ~op;
        bus.req1_a = a ^ 4'hF; bus.req1_b = b ^ 4'hF; bus.req1_op = ~op;
        #1;
        chk({tag, " exec_busy"}, 32'(bus.busy), 32'd1);
        tick;
        #1;
        chk({tag, " rsp_valid"}, 32'(r ? bus.rsp1_valid : bus.rsp0_valid), 32'd1);
        chk({tag, " other_rsp_valid"}, 32'(r ? bus.rsp0_valid : bus.rsp1_valid), 32'd0);
        chk({tag, " data"}, 32'(bus.rsp_data), 32'(ed));
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(ee));
        tick;
        exp_done++;
        #1;
        chk({tag, " done_cnt"}, 32'(bus.done_cnt), 32'(exp_done));
        chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        tick;
    endtask

    initial begin
        // Reset values, with a request pending to show ready is held low
        rst = 1'b1;
        idle_inputs();
        bus.req0_valid = 1'b1;
        tick; tick;
        #1;
        chk("rst req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done_cnt", 32'(bus.done_cnt), 32'd0);

        // Single add, granted on the first edge after reset release
        tick;
        rst = 1'b0;
        do_op(1'b0, 3'b000, 4'd9, 4'd7, 8'h10, 1'b0, "add9_7");

        // Contention from a fresh reset: grants 0,1,0,1
        rst = 1'b1;
        #1;
        chk("rst2 done_cnt", 32'(bus.done_cnt), 32'd0);
        exp_done = 0;
        tick;
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 4'd3; bus.req0_b = 4'd5;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b001; bus.req1_a = 4'd3; bus.req1_b = 4'd5;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr req0_ready", 32'(bus.req0_ready), 32'((g % 2) == 0));
            chk("rr req1_ready", 32'(bus.req1_ready), 32'((g % 2) == 1));
            tick; tick;
            #1;
            chk("rr rsp0_valid", 32'(bus.rsp0_valid), 32'((g % 2) == 0));
            chk("rr rsp1_valid", 32'(bus.rsp1_valid), 32'((g % 2) == 1));
            chk("rr data", 32'(bus.rsp_data), ((g % 2) == 0) ? 32'h0F : 32'hFE);
            tick;
            exp_done++;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        chk("rr done_cnt", 32'(bus.done_cnt), 32'(exp_done));
        tick;

        // Opcode table including divide-by-zero and illegal opcodes
        do_op(1'b1, 3'b011, 4'd15, 4'd0, 8'hFF, 1'b1, "div_by0");
        do_op(1'b0, 3'b011, 4'd15, 4'd4, 8'h03, 1'b0, "div15_4");
        do_op(1'b1, 3'b111, 4'd6,  4'd2, 8'h00, 1'b1, "op111");
        do_op(1'b0, 3'b110, 4'd6,  4'd2, 8'h00, 1'b1, "op110");
        do_op(1'b1, 3'b100, 4'd12, 4'd10, 8'h08, 1'b0, "and");
        do_op(1'b0, 3'b101, 4'd12, 4'd3, 8'h0F, 1'b0, "or");
        do_op(1'b1, 3'b001, 4'd2,  4'd9, 8'hF9, 1'b0, "sub_wrap");
        do_op(1'b0, 3'b010, 4'd15, 4'd15, 8'hE1, 1'b0, "mul_max");
        do_op(1'b1, 3'b000, 4'd15, 4'd15, 8'h1E, 1'b0, "add_max");

        // Backpressure on requester 1 while requester 0 waits
        bus.req1_valid = 1'b1; bus.req1_op = 3'b000; bus.req1_a = 4'd5; bus.req1_b = 4'd6;
        bus.rsp1_ready = 1'b0;
        #1;
        chk("bp grant1", 32'(bus.req1_ready), 32'd1);
        tick;
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
        bus.rsp0_ready = 1'b1;
        #1;
        chk("bp exec req0_ready", 32'(bus.req0_ready), 32'd0);
        tick;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            chk("bp rsp_data", 32'(bus.rsp_data), 32'h0B);
            chk("bp req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("bp rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            tick;
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp release rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("bp release done_cnt", 32'(bus.done_cnt), 32'(exp_done));
        tick;
        exp_done++;
        #1;
        chk("bp done_cnt", 32'(bus.done_cnt), 32'(exp_done));
        chk("bp rsp1_valid off", 32'(bus.rsp1_valid), 32'd0);
        chk("bp waiting req0 granted", 32'(bus.req0_ready), 32'd1);
        tick;
        bus.req0_valid = 1'b0;
        tick;
        #1;
        chk("bp req0 rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("bp req0 data", 32'(bus.rsp_data), 32'h03);
        tick;
        exp_done++;
        #1;
        chk("bp req0 done_cnt", 32'(bus.done_cnt), 32'(exp_done));
        tick;

        // Reset while in EXEC discards the operation
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 4'd15; bus.req0_b = 4'd15;
        bus.rsp0_ready = 1'b1;
        tick;
        #1;
        chk("rexec busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        exp_done = 0;
        #1;
        chk("rexec busy", 32'(bus.busy), 32'd0);
        chk("rexec req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rexec rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rexec rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rexec done_cnt", 32'(bus.done_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            chk("rexec rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            chk("rexec rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        end
        tick;
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rexec post rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            chk("rexec post done_cnt", 32'(bus.done_cnt), 32'd0);
            tick;
        end

        // 256 back-to-back completions wrap done_cnt to 0
        bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.rsp0_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick; tick; tick;
            if (i == 254) begin
                #1;
                chk("wrap done_cnt 255", 32'(bus.done_cnt), 32'd255);
            end
        end
        bus.req0_valid = 1'b0;
        #1;
        chk("wrap done_cnt 0", 32'(bus.done_cnt), 32'd0);
        chk("wrap busy", 32'(bus.busy), 32'd0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
